// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register file with per-register pending-write scoreboard
module regfile_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              pend_set,
    input  logic [ADDR_W-1:0] pend_addr,
    output logic              pend_a,
    output logic              pend_b,
    output logic              stall,
    output logic [ADDR_W:0]   pend_count,
    output logic              pend_err
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pend_next;
    logic [ADDR_W:0]     count_next;
    logic                wr_hit;
    logic                set_hit;
    logic                err_hit;
    logic                fwd_a;
    logic                fwd_b;

    assign wr_hit  = wr_en && (wr_addr != '0);
    assign set_hit = pend_set && (pend_addr != '0);

    // An issue on the same edge as the old writeback is a fresh dependency, so set wins.
    assign err_hit = set_hit && pending[pend_addr] && !(wr_hit && (wr_addr == pend_addr));

    always_comb begin
        pend_next = pending;
        if (wr_hit) begin
            pend_next[wr_addr] = 1'b0;
        end
        if (set_hit) begin
            pend_next[pend_addr] = 1'b1;
        end
        pend_next[0] = 1'b0;
    end

    always_comb begin
        count_next = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            count_next = count_next + {{ADDR_W{1'b0}}, pend_next[i]};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            pending    <= '0;
            pend_count <= '0;
            pend_err   <= 1'b0;
        end else begin
            if (wr_hit) begin
                regs[wr_addr] <= wr_data;
            end
            pending    <= pend_next;
            pend_count <= count_next;
            if (err_hit) begin
                pend_err <= 1'b1;
            end
        end
    end

    // Forwarding is suppressed while in reset so reads return 0 regardless of wr_en.
    assign fwd_a = (BYPASS != 0) && reset_n && wr_en && (wr_addr == rd_addr_a);
    assign fwd_b = (BYPASS != 0) && reset_n && wr_en && (wr_addr == rd_addr_b);

    always_comb begin
        rd_data_a = '0;
        if (rd_addr_a != '0) begin
            rd_data_a = fwd_a ? wr_data : regs[rd_addr_a];
        end
    end

    always_comb begin
        rd_data_b = '0;
        if (rd_addr_b != '0) begin
            rd_data_b = fwd_b ? wr_data : regs[rd_addr_b];
        end
    end

    assign pend_a = pending[rd_addr_a] && !fwd_a;
    assign pend_b = pending[rd_addr_b] && !fwd_b;
    assign stall  = pend_a || pend_b;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - randomized model-checked bench for regfile_scoreboard
module tb_regfile_scoreboard;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic        pend_set;
    logic [4:0]  pend_addr;

    logic [31:0] rd_data_a, rd_data_b, rd_data_a0, rd_data_b0;
    logic        pend_a, pend_b, stall, pend_err;
    logic        pend_a0, pend_b0, stall0, pend_err0;
    logic [5:0]  pend_count, pend_count0;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 0;

    bit [31:0] m_regs [32];
    bit [31:0] m_pend;
    bit        m_err;

    always #5 clock = ~clock;

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut (
        .clock(clock), .reset_n(reset_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .pend_set(pend_set), .pend_addr(pend_addr),
        .pend_a(pend_a), .pend_b(pend_b), .stall(stall),
        .pend_count(pend_count), .pend_err(pend_err)
    );

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut0 (
        .clock(clock), .reset_n(reset_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a0), .rd_data_b(rd_data_b0),
        .pend_set(pend_set), .pend_addr(pend_addr),
        .pend_a(pend_a0), .pend_b(pend_b0), .stall(stall0),
        .pend_count(pend_count0), .pend_err(pend_err0)
    );

    // Architectural model: an array of registers plus a set of outstanding destinations.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 0;
            m_pend = 0;
            m_err  = 0;
        end else begin
            bit cleared_same;
            cleared_same = wr_en && wr_addr != 0 && wr_addr == pend_addr;
            if (pend_set && pend_addr != 0 && m_pend[pend_addr] && !cleared_same) m_err = 1;
            if (wr_en && wr_addr != 0) begin
                m_regs[wr_addr] = wr_data;
                m_pend[wr_addr] = 0;
            end
            if (pend_set && pend_addr != 0) m_pend[pend_addr] = 1;
        end
    end

    function automatic bit [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (a == 0 || !reset_n) return 0;
        if (byp && wr_en && wr_addr == a) return wr_data;
        return m_regs[a];
    endfunction

    function automatic bit exp_pend(input logic [4:0] a, input bit byp);
        if (a == 0) return 0;
        if (byp && reset_n && wr_en && wr_addr == a) return 0;
        return m_pend[a];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_on) begin
            chk("rd_data_a", rd_data_a, exp_rd(rd_addr_a, 1));
            chk("rd_data_b", rd_data_b, exp_rd(rd_addr_b, 1));
            chk("pend_a", {31'b0, pend_a}, {31'b0, exp_pend(rd_addr_a, 1)});
            chk("pend_b", {31'b0, pend_b}, {31'b0, exp_pend(rd_addr_b, 1)});
            chk("stall", {31'b0, stall}, {31'b0, exp_pend(rd_addr_a, 1) | exp_pend(rd_addr_b, 1)});
            chk("pend_count", {26'b0, pend_count}, $countones(m_pend));
            chk("pend_err", {31'b0, pend_err}, {31'b0, m_err});
            chk("nb_rd_data_a", rd_data_a0, exp_rd(rd_addr_a, 0));
            chk("nb_rd_data_b", rd_data_b0, exp_rd(rd_addr_b, 0));
            chk("nb_stall", {31'b0, stall0}, {31'b0, exp_pend(rd_addr_a, 0) | exp_pend(rd_addr_b, 0)});
            chk("nb_pend_count", {26'b0, pend_count0}, $countones(m_pend));
            chk("nb_pend_err", {31'b0, pend_err0}, {31'b0, m_err});
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        wr_en = 0; pend_set = 0;
    endtask

    initial begin
        reset_n = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
        rd_addr_a = 0; rd_addr_b = 0; pend_set = 0; pend_addr = 0;
        #1;
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i);
            #1;
            chk("reset_rd_a", rd_data_a, 32'h0);
        end
        chk("reset_count", {26'b0, pend_count}, 32'd0);
        chk("reset_err", {31'b0, pend_err}, 32'd0);
        chk("reset_stall", {31'b0, stall}, 32'd0);
        step();
        chk_on = 1;
        step();
        reset_n = 1;
        step();

        wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
        step();
        idle(); rd_addr_a = 5; rd_addr_b = 5;
        #2;
        chk("wr_r5_a", rd_data_a, 32'hDEADBEEF);
        chk("wr_r5_b", rd_data_b, 32'hDEADBEEF);
        wr_en = 1; wr_addr = 0; wr_data = 32'h12345678;
        step();
        idle(); rd_addr_a = 0;
        #2;
        chk("r0_zero", rd_data_a, 32'h0);

        wr_en = 1; wr_addr = 7; wr_data = 32'h11111111;
        step();
        wr_en = 1; wr_addr = 7; wr_data = 32'hA5A5A5A5; rd_addr_a = 7;
        #2;
        chk("bypass_fwd", rd_data_a, 32'hA5A5A5A5);
        chk("nobypass_old", rd_data_a0, 32'h11111111);
        step();
        idle();

        pend_set = 1; pend_addr = 9;
        step();
        idle(); rd_addr_b = 9;
        #2;
        chk("sb_pend_b", {31'b0, pend_b}, 32'd1);
        chk("sb_stall", {31'b0, stall}, 32'd1);
        chk("sb_count1", {26'b0, pend_count}, 32'd1);
        wr_en = 1; wr_addr = 9; wr_data = 32'h55;
        #2;
        chk("sb_pend_b_fwd", {31'b0, pend_b}, 32'd0);
        chk("sb_pend_b_nobyp", {31'b0, pend_b0}, 32'd1);
        step();
        idle();
        #2;
        chk("sb_count0", {26'b0, pend_count}, 32'd0);

        pend_set = 1; pend_addr = 3;
        step();
        pend_set = 1; pend_addr = 3; wr_en = 1; wr_addr = 3; wr_data = 32'h33;
        step();
        idle(); rd_addr_a = 3;
        #2;
        chk("setclr_same_pend", {31'b0, pend_a}, 32'd1);
        chk("setclr_same_count", {26'b0, pend_count}, 32'd1);
        chk("setclr_same_noerr", {31'b0, pend_err}, 32'd0);
        pend_set = 1; pend_addr = 4; wr_en = 1; wr_addr = 3; wr_data = 32'h44;
        step();
        idle();
        #2;
        chk("setclr_diff_count", {26'b0, pend_count}, 32'd1);
        pend_set = 1; pend_addr = 4;
        step();
        idle();
        step();
        chk("err_sticky", {31'b0, pend_err}, 32'd1);

        for (int c = 0; c < 3000; c++) begin
            wr_en     = ($urandom_range(0, 2) == 0);
            wr_addr   = 5'($urandom);
            wr_data   = $urandom;
            pend_set  = ($urandom_range(0, 2) == 0);
            pend_addr = 5'($urandom);
            rd_addr_a = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
            rd_addr_b = ($urandom_range(0, 3) == 0) ? pend_addr : 5'($urandom);
            if ($urandom_range(0, 300) == 0) begin
                reset_n = 0;
                #2;
                reset_n = 1;
            end
            step();
        end

        idle();
        reset_n = 0;
        #2;
        reset_n = 1;
        step();
        for (int i = 1; i < 32; i++) begin
            pend_set = 1; pend_addr = 5'(i);
            step();
        end
        idle(); rd_addr_a = 12; rd_addr_b = 31;
        #2;
        chk("full_count", {26'b0, pend_count}, 32'd31);
        chk("full_stall", {31'b0, stall}, 32'd1);
        step();
        reset_n = 0;
        #1;
        chk("midrst_count", {26'b0, pend_count}, 32'd0);
        chk("midrst_stall", {31'b0, stall}, 32'd0);
        chk("midrst_rd_a", rd_data_a, 32'h0);
        @(negedge clock);
        #2;
        reset_n = 1;
        step();
        step();

        chk_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- 32-entry x 32-bit register file with a per-register pending-write scoreboard.
- Sits directly upstream of the operand-select stage and feeds its two read ports (A/B) to decode/execute.
- Pending bits track destinations of in-flight multicycle ops (mult/div, loads) so decode can stall on RAW hazards until writeback.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W
- BYPASS, 1, 1 = same-cycle write-to-read forwarding; 0 = reads return stored value only

Ports:
- clock  input  1  single system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- wr_en  input  1  writeback enable
- wr_addr  input  ADDR_W  writeback destination
- wr_data  input  DATA_W  writeback data
- rd_addr_a  input  ADDR_W  read port A address
- rd_addr_b  input  ADDR_W  read port B address
- rd_data_a  output  DATA_W  read port A data (combinational)
- rd_data_b  output  DATA_W  read port B data (combinational)
- pend_set  input  1  mark pend_addr as awaiting writeback
- pend_addr  input  ADDR_W  destination being issued
- pend_a  output  1  rd_addr_a has an outstanding write
- pend_b  output  1  rd_addr_b has an outstanding write
- stall  output  1  pend_a | pend_b
- pend_count  output  ADDR_W+1  number of set pending bits (registered)
- pend_err  output  1  sticky: pend_set hit an already-pending register

Behaviour:
Reset
- reset_n low, asynchronously: all registers = 0, all pending bits = 0, pend_count = 0, pend_err = 0.
- Reads stay combinational during reset and return 0.
- Reset mid-operation discards all in-flight pending state.

Register 0
- Writes to r0 are ignored; r0 always reads 0.
- pend_set with pend_addr = 0 is ignored.
- pend_a/pend_b are always 0 for address 0.

Write
- On rising edge with wr_en = 1 and wr_addr != 0: regs[wr_addr] <= wr_data.
- The same edge clears pending[wr_addr].

Read
- rd_data_x = 0 if rd_addr_x == 0.
- Else, if BYPASS and wr_en and wr_addr == rd_addr_x: rd_data_x = wr_data (zero-cycle forward).
- Else rd_data_x = regs[rd_addr_x].
- Both ports are independent and may address the same register.

Pending flags
- pend_x = pending[rd_addr_x], masked to 0 when BYPASS and wr_en and wr_addr == rd_addr_x (data is forwarded this cycle).
- With BYPASS = 0, no masking: the flag drops the cycle after writeback.

Pending set/clear
- pend_set and pend_addr != 0: pending[pend_addr] <= 1 on the rising edge.
- Same edge, same address as a write clear: set wins. This is a new issue after the old writeback.
- pend_set to an already-pending register (and not cleared this same edge): bit stays 1, pend_err <= 1.
- pend_err clears only on reset.

pend_count
- Next value = popcount of the next pending vector; always in 0..NUM_REGS-1.
- Simultaneous set on register X and clear on register Y != X: count unchanged.

Latency
- Reads are combinational.
- Writes and pending updates are visible one edge later, except through the bypass path.

Test Plan:
- Reset: hold reset_n = 0, sweep rd_addr_a over 0..31 -> rd_data_a = 0 every time; pend_count = 0, pend_err = 0, stall = 0.
- Write/read: write r5 = 0xDEADBEEF, then read A = 5, B = 5 -> both 0xDEADBEEF. Write r0 = 0x12345678 -> r0 still reads 0.
- Bypass: wr_en = 1, wr_addr = 7, wr_data = 0xA5A5A5A5, rd_addr_a = 7 in the same cycle -> rd_data_a = 0xA5A5A5A5 before the edge. With BYPASS = 0 -> the old value is returned.
- Scoreboard: pend_set r9, then rd_addr_b = 9 -> pend_b = 1, stall = 1, pend_count = 1. Next, wr_en to r9 = 0x55 -> same cycle pend_b = 0 (BYPASS = 1); after the edge pend_count = 0.
- Simultaneous set/clear:
  - pend_set r3 plus wr_en r3 on the same edge -> pending[3] stays 1, pend_count unchanged.
  - pend_set r4 plus write r3 (r3 pending) -> pend_count unchanged.
  - pend_set r4 again while pending -> pend_err = 1 (sticky).
- Async reset mid-flight: set pending r1..r31 (pend_count = 31), pulse reset_n low between edges -> immediate pend_count = 0, stall = 0, all reads 0.
